iomem_arbiter: RTL and testbench

Two-master arbiter sharing one PicoRV32-style iomem slave bus between the CPU's iomem port (m0) and a secondary bus master (m1, e.g. a video/DMA engine). It grants the slave to one master at a time using round-robin priority. A bus-timeout watchdog completes any transaction the slave never acknowledges, so a dead peripheral cannot hang the CPU.

---
 rtl/iomem_arbiter.sv | 148 ++++++++++++++
 tb/tb_iomem_arbiter.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// iomem_arbiter: round-robin arbiter sharing one PicoRV32-style iomem slave
// between two masters (m0 = CPU, m1 = secondary bus master). A per-transaction
// watchdog forces completion if the slave never answers, so a dead peripheral
// cannot hang either master.
module iomem_arbiter #(
    parameter int          TIMEOUT       = 256,
    parameter logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_valid,
    output logic        m0_ready,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    output logic        m1_ready,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    input  logic        s_ready,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic [31:0] s_rdata,

    output logic [1:0]  grant,
    output logic        timeout_flag,
    input  logic        timeout_clr
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Counter value on the cycle a forced completion happens; wraps harmlessly
    // when the watchdog is disabled because WDOG_EN masks the compare.
    localparam logic [15:0] LIMIT   = 16'(TIMEOUT - 1);
    localparam bit          WDOG_EN = (TIMEOUT != 0);

    state_t      state_reg;
    logic        sel_reg;
    logic        last_reg;
    logic [15:0] cnt_reg;
    logic        flag_reg;

    // Masters gathered into arrays so the owner can be selected by index.
    logic        m_valid [2];
    logic [3:0]  m_wstrb [2];
    logic [31:0] m_addr  [2];
    logic [31:0] m_wdata [2];
    logic        m_ready [2];
    logic [31:0] m_rdata [2];

    assign m_valid[0] = m0_valid;
    assign m_valid[1] = m1_valid;
    assign m_wstrb[0] = m0_wstrb;
    assign m_wstrb[1] = m1_wstrb;
    assign m_addr[0]  = m0_addr;
    assign m_addr[1]  = m1_addr;
    assign m_wdata[0] = m0_wdata;
    assign m_wdata[1] = m1_wdata;

    // Outputs are forced low while rst is high, even if the state register
    // still holds BUSY from before the reset edge.
    logic        busy;
    logic        sel_valid;
    logic        done_normal;
    logic        done_timeout;
    logic        done;
    logic [31:0] resp_rdata;

    assign busy         = (state_reg == BUSY) && !rst;
    assign sel_valid    = m_valid[sel_reg];
    assign done_normal  = busy && sel_valid && s_ready;
    // A slave answer on the very last watchdog cycle takes precedence.
    assign done_timeout = busy && sel_valid && !s_ready && WDOG_EN && (cnt_reg == LIMIT);
    assign done         = done_normal || done_timeout;
    assign resp_rdata   = done_normal ? s_rdata : TIMEOUT_RDATA;

    // Per-master response and grant; the loser always sees ready=0, rdata=0.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign m_ready[gi] = done && (sel_reg == 1'(gi));
            assign m_rdata[gi] = m_ready[gi] ? resp_rdata : 32'h0;
            assign grant[gi]   = busy && (sel_reg == 1'(gi));
        end
    endgenerate

    assign m0_ready = m_ready[0];
    assign m1_ready = m_ready[1];
    assign m0_rdata = m_rdata[0];
    assign m1_rdata = m_rdata[1];

    assign s_valid      = busy && sel_valid;
    assign s_wstrb      = busy ? m_wstrb[sel_reg] : 4'h0;
    assign s_addr       = busy ? m_addr[sel_reg]  : 32'h0;
    assign s_wdata      = busy ? m_wdata[sel_reg] : 32'h0;
    assign timeout_flag = flag_reg && !rst;

    // Arbitration FSM, watchdog counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= 1'b0;
            last_reg  <= 1'b1;
            cnt_reg   <= 16'h0;
            flag_reg  <= 1'b0;
        end else begin
            if (done_timeout) begin
                flag_reg <= 1'b1;
            end else if (timeout_clr) begin
                flag_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (m_valid[0] || m_valid[1]) begin
                        state_reg <= BUSY;
                        cnt_reg   <= 16'h0;
                        // On a tie the master that was served last yields.
                        sel_reg   <= (m_valid[0] && m_valid[1]) ? ~last_reg : m_valid[1];
                    end
                end
                BUSY: begin
                    if (!sel_valid) begin
                        state_reg <= IDLE;
                    end else if (done) begin
                        state_reg <= IDLE;
                        last_reg  <= sel_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 16'h1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_arbiter.sv
// Testbench for iomem_arbiter: directed table, hand-written multi-cycle
// sequences and a randomized run checked against a behavioural model.
module tb_iomem_arbiter;

    localparam int TMO = 16;

    logic        clk, rst;
    logic        m0_valid, m0_ready, m1_valid, m1_ready;
    logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
    logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
    logic        s_valid, s_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  grant;
    logic        timeout_flag, timeout_clr;

    // Second instance with the watchdog disabled.
    logic        b_m0_valid, b_m0_ready, b_m1_valid, b_m1_ready;
    logic [3:0]  b_m0_wstrb, b_m1_wstrb, b_s_wstrb;
    logic [31:0] b_m0_addr, b_m0_wdata, b_m0_rdata, b_m1_addr, b_m1_wdata, b_m1_rdata;
    logic        b_s_valid, b_s_ready;
    logic [31:0] b_s_addr, b_s_wdata, b_s_rdata;
    logic [1:0]  b_grant;
    logic        b_timeout_flag, b_timeout_clr;

    iomem_arbiter #(.TIMEOUT(TMO), .TIMEOUT_RDATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_wstrb(m0_wstrb),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_wstrb(m1_wstrb),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_ready(s_ready), .s_wstrb(s_wstrb),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
        .grant(grant), .timeout_flag(timeout_flag), .timeout_clr(timeout_clr)
    );

    iomem_arbiter #(.TIMEOUT(0)) dut_nowd (
        .clk(clk), .rst(rst),
        .m0_valid(b_m0_valid), .m0_ready(b_m0_ready), .m0_wstrb(b_m0_wstrb),
        .m0_addr(b_m0_addr), .m0_wdata(b_m0_wdata), .m0_rdata(b_m0_rdata),
        .m1_valid(b_m1_valid), .m1_ready(b_m1_ready), .m1_wstrb(b_m1_wstrb),
        .m1_addr(b_m1_addr), .m1_wdata(b_m1_wdata), .m1_rdata(b_m1_rdata),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_wstrb(b_s_wstrb),
        .s_addr(b_s_addr), .s_wdata(b_s_wdata), .s_rdata(b_s_rdata),
        .grant(b_grant), .timeout_flag(b_timeout_flag), .timeout_clr(b_timeout_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model: who owns the bus, for how many cycles, who went last.
    bit md_busy  = 1'b0;
    int md_owner = 0;
    int md_last  = 1;
    int md_age   = 0;
    bit md_flag  = 1'b0;
    bit exp_r0, exp_r1;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every output against the model for this cycle, then advance
    // the model across the clock edge. Called at a falling edge.
    task automatic step(input string name);
        logic [1:0]   e_grant;
        logic         e_sv, e_r0, e_r1, e_fl;
        logic [3:0]   e_ws;
        logic [31:0]  e_sa, e_sd, e_d0, e_d1, rd;
        logic [137:0] e_vec, a_vec;
        bit ov, fin_ok, fin_to, n_busy, n_flag;
        int n_owner, n_last, n_age;
        #1;
        e_grant = 2'b00; e_sv = 1'b0; e_r0 = 1'b0; e_r1 = 1'b0; e_fl = 1'b0;
        e_ws = 4'h0; e_sa = 32'h0; e_sd = 32'h0; e_d0 = 32'h0; e_d1 = 32'h0;
        ov = 1'b0; fin_ok = 1'b0; fin_to = 1'b0;
        if (!rst) begin
            e_fl = md_flag;
            if (md_busy) begin
                ov      = (md_owner == 1) ? m1_valid : m0_valid;
                e_grant = (md_owner == 1) ? 2'b10 : 2'b01;
                e_sv    = ov;
                e_ws    = (md_owner == 1) ? m1_wstrb : m0_wstrb;
                e_sa    = (md_owner == 1) ? m1_addr  : m0_addr;
                e_sd    = (md_owner == 1) ? m1_wdata : m0_wdata;
                fin_ok  = ov && s_ready;
                fin_to  = ov && !s_ready && (md_age + 1 == TMO);
                if (fin_ok || fin_to) begin
                    rd = fin_ok ? s_rdata : 32'hDEAD_BEEF;
                    if (md_owner == 1) begin e_r1 = 1'b1; e_d1 = rd; end
                    else begin e_r0 = 1'b1; e_d0 = rd; end
                end
            end
        end
        e_vec = {e_grant, e_sv, e_ws, e_sa, e_sd, e_r0, e_d0, e_r1, e_d1, e_fl};
        a_vec = {grant, s_valid, s_wstrb, s_addr, s_wdata, m0_ready, m0_rdata,
                 m1_ready, m1_rdata, timeout_flag};
        vectors++;
        if (a_vec !== e_vec) begin
            miscompares++;
            $display("FAIL %s: outputs got %h expected %h", name, a_vec, e_vec);
        end
        exp_r0 = e_r0;
        exp_r1 = e_r1;

        n_busy = md_busy; n_owner = md_owner; n_last = md_last; n_age = md_age; n_flag = md_flag;
        if (rst) begin
            n_busy = 1'b0; n_last = 1; n_age = 0; n_flag = 1'b0;
        end else begin
            if (fin_to) n_flag = 1'b1;
            else if (timeout_clr) n_flag = 1'b0;
            if (!md_busy) begin
                if (m0_valid || m1_valid) begin
                    n_busy  = 1'b1;
                    n_age   = 0;
                    n_owner = (m0_valid && m1_valid) ? ((md_last == 1) ? 0 : 1) : (m1_valid ? 1 : 0);
                end
            end else if (!ov) begin
                n_busy = 1'b0;
            end else if (fin_ok || fin_to) begin
                n_busy = 1'b0;
                n_last = md_owner;
            end else begin
                n_age = md_age + 1;
            end
        end
        @(posedge clk);
        md_busy = n_busy; md_owner = n_owner; md_last = n_last; md_age = n_age; md_flag = n_flag;
        @(negedge clk);
    endtask

    typedef struct {
        bit          rst, m0v, m1v, sr;
        logic [31:0] srd;
        logic [1:0]  grant;
        bit          sv, r0, r1;
        logic [31:0] d0, d1;
    } vec_t;

    vec_t tbl[17];
    bit   stall;
    bit   b_hit;

    initial begin
        rst = 1'b1; timeout_clr = 1'b0;
        m0_valid = 1'b0; m0_wstrb = 4'h0; m0_addr = 32'h0300_0010; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_wstrb = 4'b0011; m1_addr = 32'h0400_0020; m1_wdata = 32'hAABB_CCDD;
        s_ready = 1'b0; s_rdata = 32'h0;
        b_m0_valid = 1'b0; b_m0_wstrb = 4'h0; b_m0_addr = 32'h0200_0000; b_m0_wdata = 32'h0;
        b_m1_valid = 1'b0; b_m1_wstrb = 4'h0; b_m1_addr = 32'h0; b_m1_wdata = 32'h0;
        b_s_ready = 1'b0; b_s_rdata = 32'h0; b_timeout_clr = 1'b0;

        //            rst m0v m1v sr  srd            grant  sv r0 r1 d0             d1
        tbl[0]  = '{0, 1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[1]  = '{0, 1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 32'h0,         32'h0};
        tbl[2]  = '{0, 1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 32'h0,         32'h0};
        tbl[3]  = '{0, 1, 0, 1, 32'h1234_5678, 2'b01, 1, 1, 0, 32'h1234_5678, 32'h0};
        tbl[4]  = '{0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[5]  = '{1, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[6]  = '{0, 1, 1, 1, 32'h1111_1111, 2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[7]  = '{0, 1, 1, 1, 32'h1111_1111, 2'b01, 1, 1, 0, 32'h1111_1111, 32'h0};
        tbl[8]  = '{0, 0, 1, 1, 32'h2222_2222, 2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[9]  = '{0, 0, 1, 1, 32'h2222_2222, 2'b10, 1, 0, 1, 32'h0,         32'h2222_2222};
        tbl[10] = '{0, 1, 1, 1, 32'h3333_3333, 2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[11] = '{0, 1, 1, 1, 32'h3333_3333, 2'b01, 1, 1, 0, 32'h3333_3333, 32'h0};
        tbl[12] = '{0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[13] = '{0, 0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         32'h0};
        tbl[14] = '{0, 0, 1, 0, 32'h0,         2'b10, 1, 0, 0, 32'h0,         32'h0};
        tbl[15] = '{0, 0, 1, 1, 32'h4444_4444, 2'b10, 1, 0, 1, 32'h0,         32'h4444_4444};
        tbl[16] = '{0, 0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 32'h0,         32'h0};

        @(negedge clk);
        #1;
        check32("reset_grant", {30'h0, grant}, 32'h0);
        check32("reset_svalid", {31'h0, s_valid}, 32'h0);
        step("reset0");
        step("reset1");
        rst = 1'b0;

        // Directed table: single read, ties, write forwarding.
        for (int i = 0; i < 17; i++) begin
            rst = tbl[i].rst; m0_valid = tbl[i].m0v; m1_valid = tbl[i].m1v;
            s_ready = tbl[i].sr; s_rdata = tbl[i].srd;
            #1;
            check32($sformatf("tbl%0d_grant", i), {30'h0, grant}, {30'h0, tbl[i].grant});
            check32($sformatf("tbl%0d_svalid", i), {31'h0, s_valid}, {31'h0, tbl[i].sv});
            check32($sformatf("tbl%0d_m0ready", i), {31'h0, m0_ready}, {31'h0, tbl[i].r0});
            check32($sformatf("tbl%0d_m1ready", i), {31'h0, m1_ready}, {31'h0, tbl[i].r1});
            check32($sformatf("tbl%0d_m0rdata", i), m0_rdata, tbl[i].d0);
            check32($sformatf("tbl%0d_m1rdata", i), m1_rdata, tbl[i].d1);
            if (tbl[i].grant == 2'b10) begin
                check32($sformatf("tbl%0d_swstrb", i), {28'h0, s_wstrb}, 32'h3);
                check32($sformatf("tbl%0d_swdata", i), s_wdata, 32'hAABB_CCDD);
            end
            step($sformatf("tbl%0d", i));
        end
        rst = 1'b0; s_ready = 1'b0; s_rdata = 32'h0;

        // Watchdog: slave never answers.
        for (int c = 0; c <= 17; c++) begin
            m0_valid = (c <= 16);
            #1;
            if (c == 15) check32("to_early_ready", {31'h0, m0_ready}, 32'h0);
            if (c == 16) begin
                check32("to_ready", {31'h0, m0_ready}, 32'h1);
                check32("to_rdata", m0_rdata, 32'hDEAD_BEEF);
                check32("to_flag_before", {31'h0, timeout_flag}, 32'h0);
            end
            if (c == 17) check32("to_flag_set", {31'h0, timeout_flag}, 32'h1);
            step($sformatf("timeout%0d", c));
        end
        timeout_clr = 1'b1;
        step("to_clr");
        timeout_clr = 1'b0;
        #1;
        check32("to_flag_cleared", {31'h0, timeout_flag}, 32'h0);
        step("to_after_clr");

        // Slave answers exactly on the watchdog cycle: normal completion wins.
        s_rdata = 32'h55AA_0F0F;
        for (int c = 0; c <= 17; c++) begin
            m0_valid = (c <= 16);
            s_ready  = (c == 16);
            #1;
            if (c == 16) begin
                check32("bnd_ready", {31'h0, m0_ready}, 32'h1);
                check32("bnd_rdata", m0_rdata, 32'h55AA_0F0F);
            end
            if (c == 17) check32("bnd_flag", {31'h0, timeout_flag}, 32'h0);
            step($sformatf("boundary%0d", c));
        end
        s_ready = 1'b0;

        // Abort: m1 drops valid while granted.
        for (int c = 0; c <= 3; c++) begin
            m1_valid = (c <= 1);
            #1;
            if (c == 1) check32("abort_grant", {30'h0, grant}, 32'h2);
            if (c == 2) check32("abort_noready", {30'h0, m1_ready, s_valid}, 32'h0);
            if (c == 3) check32("abort_idle", {30'h0, grant}, 32'h0);
            step($sformatf("abort%0d", c));
        end

        // Reset while m1 is granted, then a tie must go to m0.
        for (int c = 0; c <= 6; c++) begin
            rst      = (c == 2);
            m1_valid = (c <= 5);
            m0_valid = (c >= 3) && (c <= 5);
            s_ready  = (c == 2) || (c == 5);
            s_rdata  = 32'h0BAD_F00D;
            #1;
            if (c == 1) check32("rstb_grant", {30'h0, grant}, 32'h2);
            if (c == 2) check32("rstb_quiet", {28'h0, grant, s_valid, m1_ready}, 32'h0);
            if (c == 3) check32("rstb_idle", {30'h0, grant}, 32'h0);
            if (c == 4) check32("rstb_tie_m0", {30'h0, grant}, 32'h1);
            if (c == 5) check32("rstb_m0_ready", {31'h0, m0_ready}, 32'h1);
            step($sformatf("rstbusy%0d", c));
        end
        rst = 1'b0; m0_valid = 1'b0; m1_valid = 1'b0; s_ready = 1'b0;

        // Watchdog disabled: a 1000+ cycle stall never forces completion.
        b_m0_valid = 1'b1;
        b_hit = 1'b0;
        for (int c = 0; c < 1002; c++) begin
            #1;
            if (b_m0_ready || b_m1_ready || b_m0_rdata != 32'h0 || b_m1_rdata != 32'h0 || b_timeout_flag)
                b_hit = 1'b1;
            step("nowd_idle");
        end
        #1;
        check32("nowd_no_ready", {31'h0, b_hit}, 32'h0);
        check32("nowd_grant", {28'h0, b_grant, b_s_valid, b_s_wstrb != 4'h0}, 32'h6);
        check32("nowd_saddr", b_s_addr ^ b_s_wdata, 32'h0200_0000);
        b_m0_valid = 1'b0;
        step("nowd_release");

        // Randomized traffic against the model.
        stall = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (n % 64 == 0) stall = ($urandom_range(0, 3) == 0);
            rst         = ($urandom_range(0, 499) == 0);
            s_ready     = stall ? 1'b0 : ($urandom_range(0, 9) < 4);
            s_rdata     = $urandom;
            timeout_clr = ($urandom_range(0, 19) == 0);
            if (!m0_valid && $urandom_range(0, 2) == 0) begin
                m0_valid = 1'b1; m0_addr = $urandom; m0_wdata = $urandom;
                m0_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end else if (m0_valid && $urandom_range(0, 63) == 0) begin
                m0_valid = 1'b0;
            end
            if (!m1_valid && $urandom_range(0, 2) == 0) begin
                m1_valid = 1'b1; m1_addr = $urandom; m1_wdata = $urandom;
                m1_wstrb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
            end else if (m1_valid && $urandom_range(0, 63) == 0) begin
                m1_valid = 1'b0;
            end
            step($sformatf("rand%0d", n));
            if (exp_r0) m0_valid = 1'b0;
            if (exp_r1) m1_valid = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
